// File: rtl/vector_sequencer.sv
// Display-list player: fetches command words, hands jump/draw targets to the beam
// controller under its ready handshake, and restarts the list at a fixed frame rate.
module vector_sequencer #(
    parameter int ADDR_W       = 10,
    parameter int FRAME_CYCLES = 833333,
    parameter int GUARD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_data,
    output logic [11:0]       x,
    output logic [11:0]       y,
    output logic              jump,
    output logic              draw,
    input  logic              ready,
    output logic              frame_done,
    output logic              overrun,
    output logic              busy
);
    localparam int TW = $clog2(FRAME_CYCLES);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [1:0] OP_NOP = 2'b00, OP_JUMP = 2'b01, OP_DRAW = 2'b10, OP_END = 2'b11;

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, DECODE, GUARD, WAIT_READY, FRAME_WAIT} state_t;
    state_t r_state, w_next;

    // Extra MSB marks that the last list word has executed (implicit END).
    logic [ADDR_W:0] r_addr;
    logic [31:0]     r_cmd;
    logic [TW-1:0]   r_timer;
    logic [GW-1:0]   r_guard;
    logic [11:0]     r_x, r_y;
    logic            r_jump, r_draw, r_frame_done, r_overrun;

    logic [1:0]      w_op;
    logic [ADDR_W:0] w_addr_inc;
    logic            w_issue, w_end, w_restart, w_start, w_timer_last, w_is_nop;
    logic            w_unused_rsvd;

    assign w_op          = r_cmd[31:30];
    assign w_unused_rsvd = ^r_cmd[29:24];
    assign w_addr_inc    = r_addr + 1'b1;
    assign w_timer_last  = (r_timer == T_LAST);
    assign w_is_nop      = (r_state == DECODE) && (w_op == OP_NOP);
    assign w_issue       = (r_state == DECODE) && ((w_op == OP_JUMP) || (w_op == OP_DRAW)) && ready;
    assign w_end         = ((r_state == DECODE) && ((w_op == OP_END) || (w_is_nop && w_addr_inc[ADDR_W])))
                         || ((r_state == WAIT_READY) && ready && r_addr[ADDR_W]);
    // A late END restarts at once and is flagged as an overrun.
    assign w_restart     = ((r_state == FRAME_WAIT) || w_end) && w_timer_last;
    assign w_start       = (r_state == IDLE) && enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_cmd        <= '0;
            r_timer      <= '0;
            r_guard      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_jump       <= 1'b0;
            r_draw       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_jump       <= w_issue && (w_op == OP_JUMP);
            r_draw       <= w_issue && (w_op == OP_DRAW);
            r_frame_done <= w_restart;
            r_overrun    <= w_restart && (r_state != FRAME_WAIT);

            if (w_start || w_restart)
                r_timer <= '0;
            else if (!w_timer_last)
                r_timer <= r_timer + 1'b1;

            if (w_start || w_restart)
                r_addr <= '0;
            else if (w_issue || w_is_nop)
                r_addr <= w_addr_inc;

            if (r_state == LATCH)
                r_cmd <= mem_data;

            r_guard <= (r_state == GUARD) ? r_guard + 1'b1 : '0;

            if (w_issue) begin
                r_x <= r_cmd[23:12];
                r_y <= r_cmd[11:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (enable) w_next = FETCH;
            FETCH:      w_next = LATCH;
            LATCH:      w_next = DECODE;
            DECODE: begin
                if (w_op == OP_NOP)
                    w_next = enable ? FETCH : IDLE;
                else if (w_issue)
                    w_next = GUARD;
            end
            GUARD:      if (r_guard == G_LAST) w_next = WAIT_READY;
            WAIT_READY: if (ready) w_next = enable ? FETCH : IDLE;
            FRAME_WAIT: w_next = FRAME_WAIT;
            default:    w_next = IDLE;
        endcase
        if (w_restart)
            w_next = enable ? FETCH : IDLE;
        else if (w_end)
            w_next = FRAME_WAIT;
    end

    always_comb begin
        mem_addr   = r_addr[ADDR_W-1:0];
        mem_rd_en  = (r_state == FETCH);
        busy       = (r_state != IDLE);
        x          = r_x;
        y          = r_y;
        jump       = r_jump;
        draw       = r_draw;
        frame_done = r_frame_done;
        overrun    = r_overrun;
    end
endmodule
